// File: rtl/hilo_md_unit.sv
// HI/LO multiply/divide unit for the execute stage: pipelined multiplier with
// MUL_LAT register stages and an iterative restoring divider, one bit per cycle.
module hilo_md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int               CNT_W        = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_DONE_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_DONE_CNT = CNT_W'(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high and cancel is low; req_ready is simply !busy,
    // so requests are only taken while idle (including the done cycle).
    logic accept;
    assign req_ready = !busy;
    assign accept    = req_valid && req_ready && !cancel;

    // Request decode
    logic             is_mul;
    logic             is_div;
    logic             mul_signed;
    logic             div_signed;
    logic             s1_neg;
    logic             s2_neg;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    always_comb begin
        is_mul     = (req_op == OP_MULT) || (req_op == OP_MULTU);
        is_div     = (req_op == OP_DIV)  || (req_op == OP_DIVU);
        mul_signed = (req_op == OP_MULT);
        div_signed = (req_op == OP_DIV);
        s1_neg     = div_signed & src1[WIDTH-1];
        s2_neg     = div_signed & src2[WIDTH-1];
        mag1       = s1_neg ? (-src1) : src1;
        mag2       = s2_neg ? (-src2) : src2;
    end

    // Multiplier: operands are extended to 2*WIDTH so one unsigned multiply
    // yields the correct low 2*WIDTH product bits for both MULT and MULTU.
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] mul_result;

    assign mul_prod = mul_a * mul_b;

    generate
        if (MUL_LAT == 1) begin : g_no_pipe
            assign mul_result = mul_prod;
        end else begin : g_pipe
            logic [2*WIDTH-1:0] stage [MUL_LAT-1];

            always_ff @(posedge clk) begin
                stage[0] <= mul_prod;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    stage[i] <= stage[i-1];
                end
            end

            assign mul_result = stage[MUL_LAT-2];
        end
    endgenerate

    // Divider: div_quo starts as the dividend magnitude and is shifted left
    // one bit per iteration while quotient bits enter at the bottom.
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_dvs;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign rem_shift = {div_rem, div_quo[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, div_dvs};
    assign q_fix     = neg_q ? (-div_quo) : div_quo;
    assign r_fix     = neg_r ? (-div_rem) : div_rem;

    // A zero divisor never restores, so the quotient becomes all ones and the
    // remainder the dividend magnitude; sign correction then gives the
    // architected divide-by-zero results without a special case.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL;
                            busy  <= 1'b1;
                            cnt   <= CNT_ONE;
                            mul_a <= {{WIDTH{mul_signed & src1[WIDTH-1]}}, src1};
                            mul_b <= {{WIDTH{mul_signed & src2[WIDTH-1]}}, src2};
                        end else if (is_div) begin
                            state   <= ST_DIV;
                            busy    <= 1'b1;
                            cnt     <= CNT_ONE;
                            div_rem <= '0;
                            div_quo <= mag1;
                            div_dvs <= mag2;
                            neg_q   <= s1_neg ^ s2_neg;
                            neg_r   <= s1_neg;
                        end else if (req_op == OP_MTHI) begin
                            hi   <= src1;
                            done <= 1'b1;
                        end else if (req_op == OP_MTLO) begin
                            lo   <= src1;
                            done <= 1'b1;
                        end
                    end
                end

                ST_MUL: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == MUL_DONE_CNT) begin
                        hi    <= mul_result[2*WIDTH-1:WIDTH];
                        lo    <= mul_result[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DIV: begin
                    if (cancel) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == DIV_DONE_CNT) begin
                        hi    <= r_fix;
                        lo    <= q_fix;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        div_rem <= rem_trial[WIDTH] ? rem_shift[WIDTH-1:0] : rem_trial[WIDTH-1:0];
                        div_quo <= {div_quo[WIDTH-2:0], ~rem_trial[WIDTH]};
                        cnt     <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: three instances (32-bit lat 1, 32-bit lat 4,
// 8-bit lat 1) driven on negedges, checked against hand-computed results.
module tb_hilo_md_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct {
        int          inst;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;

    logic        valid_in  [3];
    logic [2:0]  op_in     [3];
    logic [31:0] s1_in     [3];
    logic [31:0] s2_in     [3];
    logic        cancel_in [3];

    logic        ready_a, busy_a, done_a;
    logic        ready_b, busy_b, done_b;
    logic        ready_c, busy_c, done_c;
    logic [31:0] hi_a, lo_a, hi_b, lo_b;
    logic [7:0]  hi_c, lo_c;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_hi [3];
    logic [31:0] exp_lo [3];

    hilo_md_unit #(.WIDTH(32), .MUL_LAT(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(valid_in[0]), .req_ready(ready_a),
        .req_op(op_in[0]), .src1(s1_in[0]), .src2(s2_in[0]), .cancel(cancel_in[0]),
        .busy(busy_a), .done(done_a), .hi(hi_a), .lo(lo_a)
    );

    hilo_md_unit #(.WIDTH(32), .MUL_LAT(4)) u_b (
        .clk(clk), .reset(reset), .req_valid(valid_in[1]), .req_ready(ready_b),
        .req_op(op_in[1]), .src1(s1_in[1]), .src2(s2_in[1]), .cancel(cancel_in[1]),
        .busy(busy_b), .done(done_b), .hi(hi_b), .lo(lo_b)
    );

    hilo_md_unit #(.WIDTH(8), .MUL_LAT(1)) u_c (
        .clk(clk), .reset(reset), .req_valid(valid_in[2]), .req_ready(ready_c),
        .req_op(op_in[2]), .src1(s1_in[2][7:0]), .src2(s2_in[2][7:0]), .cancel(cancel_in[2]),
        .busy(busy_c), .done(done_c), .hi(hi_c), .lo(lo_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hi_of(input int i);
        if (i == 0) return hi_a;
        if (i == 1) return hi_b;
        return {24'h0, hi_c};
    endfunction

    function automatic logic [31:0] lo_of(input int i);
        if (i == 0) return lo_a;
        if (i == 1) return lo_b;
        return {24'h0, lo_c};
    endfunction

    function automatic logic busy_of(input int i);
        if (i == 0) return busy_a;
        if (i == 1) return busy_b;
        return busy_c;
    endfunction

    function automatic logic done_of(input int i);
        if (i == 0) return done_a;
        if (i == 1) return done_b;
        return done_c;
    endfunction

    function automatic logic ready_of(input int i);
        if (i == 0) return ready_a;
        if (i == 1) return ready_b;
        return ready_c;
    endfunction

    task automatic drive(input int i, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        valid_in[i] = v;
        op_in[i]    = op;
        s1_in[i]    = a;
        s2_in[i]    = b;
    endtask

    // Presents one request for a single edge, scrambles the operands after
    // edge 0, then waits (bounded) for done. lat = edges from edge 0 to the
    // write edge, or -1 on timeout; busy_n = cycles busy was seen high.
    task automatic run_op(input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int busy_n);
        drive(i, 1'b1, op, a, b);
        @(negedge clk);
        drive(i, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k <= 60; k++) begin
            if (done_of(i)) begin
                lat = k;
                break;
            end
            if (busy_of(i)) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (busy_of(i) !== 1'b0) begin n_err++; $display("FAIL reset busy[%0d]: got %b want 0", i, busy_of(i)); end
            n_vec++; if (done_of(i) !== 1'b0) begin n_err++; $display("FAIL reset done[%0d]: got %b want 0", i, done_of(i)); end
            n_vec++; if (ready_of(i) !== 1'b1) begin n_err++; $display("FAIL reset ready[%0d]: got %b want 1", i, ready_of(i)); end
            n_vec++; if (hi_of(i) !== 32'h0) begin n_err++; $display("FAIL reset hi[%0d]: got %h want 0", i, hi_of(i)); end
            n_vec++; if (lo_of(i) !== 32'h0) begin n_err++; $display("FAIL reset lo[%0d]: got %h want 0", i, lo_of(i)); end
            exp_hi[i] = '0;
            exp_lo[i] = '0;
        end
    endtask

    task automatic test_mult;
        vec_t t [5];
        int   lat, bn;
        t[0] = '{0, OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1};
        t[1] = '{0, OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1};
        t[2] = '{1, OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 4};
        t[3] = '{1, OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 4};
        t[4] = '{1, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4};
        foreach (t[j]) begin
            run_op(t[j].inst, t[j].op, t[j].a, t[j].b, lat, bn);
            n_vec++; if (lat !== t[j].lat) begin n_err++; $display("FAIL mult[%0d] latency: got %0d want %0d", j, lat, t[j].lat); end
            n_vec++; if (bn !== t[j].lat) begin n_err++; $display("FAIL mult[%0d] busy cycles: got %0d want %0d", j, bn, t[j].lat); end
            n_vec++; if (busy_of(t[j].inst) !== 1'b0) begin n_err++; $display("FAIL mult[%0d] busy at done: got 1 want 0", j); end
            n_vec++; if (hi_of(t[j].inst) !== t[j].h) begin n_err++; $display("FAIL mult[%0d] hi: got %h want %h", j, hi_of(t[j].inst), t[j].h); end
            n_vec++; if (lo_of(t[j].inst) !== t[j].l) begin n_err++; $display("FAIL mult[%0d] lo: got %h want %h", j, lo_of(t[j].inst), t[j].l); end
            @(negedge clk);
            n_vec++; if (done_of(t[j].inst) !== 1'b0) begin n_err++; $display("FAIL mult[%0d] done width: got 1 want 0", j); end
            exp_hi[t[j].inst] = t[j].h;
            exp_lo[t[j].inst] = t[j].l;
        end
    endtask

    task automatic test_div;
        vec_t t [4];
        int   lat, bn;
        t[0] = '{0, OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        t[1] = '{0, OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        t[2] = '{0, OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        t[3] = '{0, OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       33};
        foreach (t[j]) begin
            run_op(t[j].inst, t[j].op, t[j].a, t[j].b, lat, bn);
            n_vec++; if (lat !== t[j].lat) begin n_err++; $display("FAIL div[%0d] latency: got %0d want %0d", j, lat, t[j].lat); end
            n_vec++; if (bn !== t[j].lat) begin n_err++; $display("FAIL div[%0d] busy cycles: got %0d want %0d", j, bn, t[j].lat); end
            n_vec++; if (busy_of(t[j].inst) !== 1'b0) begin n_err++; $display("FAIL div[%0d] busy at done: got 1 want 0", j); end
            n_vec++; if (hi_of(t[j].inst) !== t[j].h) begin n_err++; $display("FAIL div[%0d] hi: got %h want %h", j, hi_of(t[j].inst), t[j].h); end
            n_vec++; if (lo_of(t[j].inst) !== t[j].l) begin n_err++; $display("FAIL div[%0d] lo: got %h want %h", j, lo_of(t[j].inst), t[j].l); end
            @(negedge clk);
            n_vec++; if (done_of(t[j].inst) !== 1'b0) begin n_err++; $display("FAIL div[%0d] done width: got 1 want 0", j); end
            exp_hi[t[j].inst] = t[j].h;
            exp_lo[t[j].inst] = t[j].l;
        end
    endtask

    task automatic test_div_corner;
        vec_t t [4];
        int   lat, bn;
        t[0] = '{0, OP_DIVU, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33};
        t[1] = '{0, OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'd1,        33};
        t[2] = '{0, OP_DIV,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 33};
        t[3] = '{0, OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33};
        foreach (t[j]) begin
            run_op(t[j].inst, t[j].op, t[j].a, t[j].b, lat, bn);
            n_vec++; if (lat !== t[j].lat) begin n_err++; $display("FAIL divc[%0d] latency: got %0d want %0d", j, lat, t[j].lat); end
            n_vec++; if (hi_of(t[j].inst) !== t[j].h) begin n_err++; $display("FAIL divc[%0d] hi: got %h want %h", j, hi_of(t[j].inst), t[j].h); end
            n_vec++; if (lo_of(t[j].inst) !== t[j].l) begin n_err++; $display("FAIL divc[%0d] lo: got %h want %h", j, lo_of(t[j].inst), t[j].l); end
            @(negedge clk);
            n_vec++; if (done_of(t[j].inst) !== 1'b0) begin n_err++; $display("FAIL divc[%0d] done width: got 1 want 0", j); end
            exp_hi[t[j].inst] = t[j].h;
            exp_lo[t[j].inst] = t[j].l;
        end
    endtask

    task automatic test_width8;
        vec_t t [4];
        int   lat, bn;
        t[0] = '{2, OP_DIVU,  32'd200,  32'd7,   32'h04, 32'h1C, 9};
        t[1] = '{2, OP_MULT,  32'h80,   32'h80,  32'h40, 32'h00, 1};
        t[2] = '{2, OP_DIV,   32'h80,   32'hFF,  32'h00, 32'h80, 9};
        t[3] = '{2, OP_MULTU, 32'hFF,   32'hFF,  32'hFE, 32'h01, 1};
        foreach (t[j]) begin
            run_op(t[j].inst, t[j].op, t[j].a, t[j].b, lat, bn);
            n_vec++; if (lat !== t[j].lat) begin n_err++; $display("FAIL w8[%0d] latency: got %0d want %0d", j, lat, t[j].lat); end
            n_vec++; if (bn !== t[j].lat) begin n_err++; $display("FAIL w8[%0d] busy cycles: got %0d want %0d", j, bn, t[j].lat); end
            n_vec++; if (hi_of(t[j].inst) !== t[j].h) begin n_err++; $display("FAIL w8[%0d] hi: got %h want %h", j, hi_of(t[j].inst), t[j].h); end
            n_vec++; if (lo_of(t[j].inst) !== t[j].l) begin n_err++; $display("FAIL w8[%0d] lo: got %h want %h", j, lo_of(t[j].inst), t[j].l); end
            @(negedge clk);
            exp_hi[t[j].inst] = t[j].h;
            exp_lo[t[j].inst] = t[j].l;
        end
    endtask

    task automatic test_mthi_mtlo;
        int lat, bn;
        run_op(0, OP_MTHI, 32'h11, $urandom, lat, bn);
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL mthi latency: got %0d want 0", lat); end
        n_vec++; if (hi_a !== 32'h11) begin n_err++; $display("FAIL mthi hi: got %h want 00000011", hi_a); end
        n_vec++; if (lo_a !== exp_lo[0]) begin n_err++; $display("FAIL mthi lo held: got %h want %h", lo_a, exp_lo[0]); end
        @(negedge clk);
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL mthi done width: got 1 want 0"); end
        run_op(0, OP_MTLO, 32'h22, $urandom, lat, bn);
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL mtlo latency: got %0d want 0", lat); end
        n_vec++; if (lo_a !== 32'h22) begin n_err++; $display("FAIL mtlo lo: got %h want 00000022", lo_a); end
        n_vec++; if (hi_a !== 32'h11) begin n_err++; $display("FAIL mtlo hi held: got %h want 00000011", hi_a); end
        @(negedge clk);
        exp_hi[0] = 32'h11;
        exp_lo[0] = 32'h22;
        run_op(2, OP_MTHI, 32'h5A, $urandom, lat, bn);
        n_vec++; if (hi_of(2) !== 32'h5A) begin n_err++; $display("FAIL mthi w8 hi: got %h want 0000005a", hi_of(2)); end
        @(negedge clk);
        exp_hi[2] = 32'h5A;
    endtask

    task automatic test_noop;
        for (int op = 6; op <= 7; op++) begin
            drive(0, 1'b1, 3'(op), 32'hCAFEF00D, 32'h12345678);
            @(negedge clk);
            drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
            n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL noop%0d done: got 1 want 0", op); end
            n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL noop%0d busy: got 1 want 0", op); end
            n_vec++; if ({hi_a, lo_a} !== {exp_hi[0], exp_lo[0]}) begin n_err++; $display("FAIL noop%0d hilo: got %h_%h want %h_%h", op, hi_a, lo_a, exp_hi[0], exp_lo[0]); end
            @(negedge clk);
            n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL noop%0d late done: got 1 want 0", op); end
        end
    endtask

    task automatic test_cancel_div;
        int lat, bn, n_done;
        drive(0, 1'b1, OP_DIV, 32'd1000, 32'd3);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL cancel_div busy before: got 0 want 1"); end
        cancel_in[0] = 1'b1;
        @(negedge clk);
        cancel_in[0] = 1'b0;
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL cancel_div busy after: got 1 want 0"); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL cancel_div done: got 1 want 0"); end
        n_vec++; if ({hi_a, lo_a} !== 64'h00000011_00000022) begin n_err++; $display("FAIL cancel_div hilo: got %h_%h want 00000011_00000022", hi_a, lo_a); end
        run_op(0, OP_MTHI, 32'h1234, $urandom, lat, bn);
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL cancel_div mthi latency: got %0d want 0", lat); end
        n_vec++; if ({hi_a, lo_a} !== 64'h00001234_00000022) begin n_err++; $display("FAIL cancel_div mthi hilo: got %h_%h want 00001234_00000022", hi_a, lo_a); end
        exp_hi[0] = 32'h1234;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL cancel_div stray done: got %0d want 0", n_done); end
        n_vec++; if (hi_a !== 32'h1234) begin n_err++; $display("FAIL cancel_div hi held: got %h want 00001234", hi_a); end
    endtask

    task automatic test_cancel_mul;
        drive(1, 1'b1, OP_MULT, 32'd5, 32'd6);
        @(negedge clk);
        drive(1, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        cancel_in[1] = 1'b1;
        @(negedge clk);
        cancel_in[1] = 1'b0;
        n_vec++; if (done_b !== 1'b0) begin n_err++; $display("FAIL cancel_mul done: got 1 want 0"); end
        n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL cancel_mul busy: got 1 want 0"); end
        n_vec++; if ({hi_b, lo_b} !== {exp_hi[1], exp_lo[1]}) begin n_err++; $display("FAIL cancel_mul hilo: got %h_%h want %h_%h", hi_b, lo_b, exp_hi[1], exp_lo[1]); end
        @(negedge clk);
        n_vec++; if (done_b !== 1'b0) begin n_err++; $display("FAIL cancel_mul late done: got 1 want 0"); end
    endtask

    task automatic test_cancel_request;
        drive(0, 1'b1, OP_MTLO, 32'hDEAD, 32'h0);
        cancel_in[0] = 1'b1;
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
        cancel_in[0] = 1'b0;
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL cancel_req mtlo done: got 1 want 0"); end
        n_vec++; if (lo_a !== exp_lo[0]) begin n_err++; $display("FAIL cancel_req mtlo lo: got %h want %h", lo_a, exp_lo[0]); end
        drive(0, 1'b1, OP_DIV, 32'd50, 32'd5);
        cancel_in[0] = 1'b1;
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
        cancel_in[0] = 1'b0;
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL cancel_req div busy: got 1 want 0"); end
    endtask

    task automatic test_back_to_back;
        int lat, bn;
        drive(0, 1'b1, OP_MTHI, 32'hA1, 32'h0);
        @(negedge clk);
        n_vec++; if ({done_a, hi_a} !== {1'b1, 32'hA1}) begin n_err++; $display("FAIL b2b 1: got done=%b hi=%h want done=1 hi=000000a1", done_a, hi_a); end
        drive(0, 1'b1, OP_MTLO, 32'hB2, 32'h0);
        @(negedge clk);
        n_vec++; if ({done_a, hi_a, lo_a} !== {1'b1, 32'hA1, 32'hB2}) begin n_err++; $display("FAIL b2b 2: got done=%b hi=%h lo=%h want 1 a1 b2", done_a, hi_a, lo_a); end
        drive(0, 1'b1, OP_MTHI, 32'hC3, 32'h0);
        @(negedge clk);
        n_vec++; if ({done_a, hi_a} !== {1'b1, 32'hC3}) begin n_err++; $display("FAIL b2b 3: got done=%b hi=%h want done=1 hi=000000c3", done_a, hi_a); end
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL b2b done drop: got 1 want 0"); end
        run_op(0, OP_MULT, 32'd3, 32'd4, lat, bn);
        n_vec++; if ({hi_a, lo_a} !== 64'h0000000C) begin n_err++; $display("FAIL b2b mult: got %h_%h want 00000000_0000000c", hi_a, lo_a); end
        n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL b2b ready in done cycle: got 0 want 1"); end
        run_op(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bn);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL b2b multu latency: got %0d want 1", lat); end
        n_vec++; if ({hi_a, lo_a} !== 64'hFFFFFFFE_00000001) begin n_err++; $display("FAIL b2b multu: got %h_%h want fffffffe_00000001", hi_a, lo_a); end
        @(negedge clk);
        exp_hi[0] = 32'hFFFFFFFE;
        exp_lo[0] = 32'h00000001;
    endtask

    task automatic test_reset_mid_div;
        int n_done;
        drive(0, 1'b1, OP_DIV, 32'd999, 32'd7);
        @(negedge clk);
        drive(0, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_mid busy: got 1 want 0"); end
        n_vec++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_mid done: got 1 want 0"); end
        n_vec++; if ({hi_a, lo_a} !== 64'h0) begin n_err++; $display("FAIL reset_mid hilo: got %h_%h want 0_0", hi_a, lo_a); end
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_a) n_done++;
        end
        n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL reset_mid stray done: got %0d want 0", n_done); end
        n_vec++; if ({hi_a, lo_a} !== 64'h0) begin n_err++; $display("FAIL reset_mid hilo later: got %h_%h want 0_0", hi_a, lo_a); end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 3'd0, 32'h0, 32'h0);
            cancel_in[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_div_corner;
        test_width8;
        test_mthi_mtlo;
        test_noop;
        test_cancel_div;
        test_cancel_mul;
        test_cancel_request;
        test_back_to_back;
        test_reset_mid_div;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
